// File: rtl/dff_bank_arbiter.sv
// -----------------------------------------------------------------------------
// dff_bank_arbiter
//
// A small bank of DEPTH x WIDTH flip-flop registers shared by two requesters.
// A two-state FSM (idle / access) grants one requester at a time, with
// round-robin priority when both ask at once. The winner's command is captured
// in idle, and the access completes in the following single access cycle.
// That cycle drives a one-cycle ack and read-before-write data.
//
// Parameters
//   WIDTH  data width of each bank entry
//   DEPTH  number of bank entries (power of two, >= 2)
//   AW     address width, log2(DEPTH)
//
// Ports
//   clk             single clock, rising edge
//   rst             asynchronous active-high reset
//   req0 / req1     access request
//   we0  / we1      1 = write, 0 = read
//   addr0 / addr1   entry index
//   wdata0 / wdata1 write data
//   ack0 / ack1     one-cycle completion strobe
//   rdata0 / rdata1 read data, valid only while the matching ack is high
// -----------------------------------------------------------------------------
module dff_bank_arbiter #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic             we0,
   input  logic [AW-1:0]    addr0,
   input  logic [WIDTH-1:0] wdata0,
   output logic             ack0,
   output logic [WIDTH-1:0] rdata0,
   input  logic             req1,
   input  logic             we1,
   input  logic [AW-1:0]    addr1,
   input  logic [WIDTH-1:0] wdata1,
   output logic             ack1,
   output logic [WIDTH-1:0] rdata1
);

   typedef enum logic {StIdle, StAccess} state_e;

   state_e           state_q, state_d;
   logic             owner_q, owner_d;         // 0 = requester 0, 1 = requester 1
   logic             cmd_we_q, cmd_we_d;
   logic [AW-1:0]    cmd_addr_q, cmd_addr_d;
   logic [WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
   logic             last_served_q, last_served_d;
   logic [WIDTH-1:0] bank_q [DEPTH];
   logic [WIDTH-1:0] bank_d [DEPTH];

   logic             grant;
   logic             in_access;
   logic [WIDTH-1:0] rd_word;

   // Next-state: arbitration, command capture and the bank write-back.
   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      cmd_we_d      = cmd_we_q;
      cmd_addr_d    = cmd_addr_q;
      cmd_wdata_d   = cmd_wdata_q;
      last_served_d = last_served_q;
      bank_d        = bank_q;
      grant         = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               // Contended: serve whoever was not served last.
               if (req0 && req1) begin
                  grant = ~last_served_q;
               end else begin
                  grant = req1;
               end
               owner_d     = grant;
               cmd_we_d    = grant ? we1    : we0;
               cmd_addr_d  = grant ? addr1  : addr0;
               cmd_wdata_d = grant ? wdata1 : wdata0;
               state_d     = StAccess;
            end
         end
         StAccess: begin
            // Always a single cycle; inputs are ignored here.
            state_d       = StIdle;
            last_served_d = owner_q;
            if (cmd_we_q) begin
               bank_d[cmd_addr_q] = cmd_wdata_q;
            end
         end
      endcase
   end

   // Outputs decode registered state only; reset clears them via state_q.
   always_comb begin
      in_access = (state_q == StAccess);
      rd_word   = bank_q[cmd_addr_q];
      ack0      = in_access && !owner_q;
      ack1      = in_access &&  owner_q;
      rdata0    = ack0 ? rd_word : '0;
      rdata1    = ack1 ? rd_word : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         owner_q       <= 1'b0;
         cmd_we_q      <= 1'b0;
         cmd_addr_q    <= '0;
         cmd_wdata_q   <= '0;
         // Makes the first contended grant after reset go to requester 0.
         last_served_q <= 1'b1;
         for (int i = 0; i < DEPTH; i++) begin
            bank_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         cmd_we_q      <= cmd_we_d;
         cmd_addr_q    <= cmd_addr_d;
         cmd_wdata_q   <= cmd_wdata_d;
         last_served_q <= last_served_d;
         for (int i = 0; i < DEPTH; i++) begin
            bank_q[i] <= bank_d[i];
         end
      end
   end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dff_bank_arbiter
//
// Directed bench for dff_bank_arbiter (WIDTH=8, DEPTH=4, AW=2). Inputs change
// on the falling edge; outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_dff_bank_arbiter;

   logic       clk;
   logic       rst;
   logic       req0, we0, ack0;
   logic [1:0] addr0;
   logic [7:0] wdata0, rdata0;
   logic       req1, we1, ack1;
   logic [1:0] addr1;
   logic [7:0] wdata1, rdata1;

   int vectors;
   int miscompares;

   dff_bank_arbiter #(
      .WIDTH (8),
      .DEPTH (4),
      .AW    (2)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .req0   (req0),
      .we0    (we0),
      .addr0  (addr0),
      .wdata0 (wdata0),
      .ack0   (ack0),
      .rdata0 (rdata0),
      .req1   (req1),
      .we1    (we1),
      .addr1  (addr1),
      .wdata1 (wdata1),
      .ack1   (ack1),
      .rdata1 (rdata1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reset for one rising edge, release on a falling edge. Optionally hold
   // both requests high across the release.
   task automatic do_reset(input bit both_req);
      @(negedge clk);
      rst  = 1'b1;
      req0 = both_req;
      req1 = both_req;
      we0  = 1'b0;
      we1  = 1'b0;
      #1;
      chk("rst_ack0", {31'b0, ack0}, 32'd0);
      chk("rst_ack1", {31'b0, ack1}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Single uncontended access. While in ACCESS the inputs are scrambled and
   // the request dropped, which must not affect the captured command.
   task automatic do_access(input bit who, input bit we, input logic [1:0] addr,
                            input logic [7:0] wdata, input logic [7:0] exp_rd,
                            input string tag);
      @(negedge clk);
      if (!who) begin
         req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
      end else begin
         req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
      end
      @(posedge clk);
      #1;
      chk({tag, "_ack"},    {31'b0, (who ? ack1 : ack0)}, 32'd1);
      chk({tag, "_oack"},   {31'b0, (who ? ack0 : ack1)}, 32'd0);
      chk({tag, "_rdata"},  {24'b0, (who ? rdata1 : rdata0)}, {24'b0, exp_rd});
      chk({tag, "_ordata"}, {24'b0, (who ? rdata0 : rdata1)}, 32'd0);
      if (!who) begin
         req0 = 1'b0; we0 = ~we; addr0 = ~addr; wdata0 = ~wdata;
      end else begin
         req1 = 1'b0; we1 = ~we; addr1 = ~addr; wdata1 = ~wdata;
      end
      @(posedge clk);
      #1;
      chk({tag, "_idle0"}, {31'b0, ack0}, 32'd0);
      chk({tag, "_idle1"}, {31'b0, ack1}, 32'd0);
   endtask

   initial begin
      logic [3:0] exp_a0;
      logic [3:0] exp_a1;
      vectors     = 0;
      miscompares = 0;
      rst    = 1'b1;
      req0   = 1'b0; we0 = 1'b0; addr0 = 2'd0; wdata0 = 8'h00;
      req1   = 1'b0; we1 = 1'b0; addr1 = 2'd0; wdata1 = 8'h00;
      #1;
      chk("reset_ack0",   {31'b0, ack0}, 32'd0);
      chk("reset_ack1",   {31'b0, ack1}, 32'd0);
      chk("reset_rdata0", {24'b0, rdata0}, 32'd0);
      chk("reset_rdata1", {24'b0, rdata1}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // All entries read zero after reset.
      for (int i = 0; i < 4; i++) begin
         do_access(1'b0, 1'b0, 2'(i), 8'h00, 8'h00, "rd_reset");
      end

      // Requester 1 write then read-back; read-before-write on the write ack.
      do_access(1'b1, 1'b1, 2'd2, 8'hA5, 8'h00, "wr1_a2");
      do_access(1'b1, 1'b0, 2'd2, 8'h00, 8'hA5, "rd1_a2");
      do_access(1'b0, 1'b0, 2'd0, 8'h00, 8'h00, "rd0_a0");
      do_access(1'b0, 1'b0, 2'd1, 8'h00, 8'h00, "rd0_a1");
      do_access(1'b0, 1'b0, 2'd3, 8'h00, 8'h00, "rd0_a3");

      // Write with inputs scrambled during ACCESS (addr -> 0, data -> 0xA5).
      do_access(1'b0, 1'b1, 2'd3, 8'h5A, 8'h00, "wr0_a3");
      do_access(1'b0, 1'b0, 2'd3, 8'h00, 8'h5A, "rd0_a3_cap");
      do_access(1'b0, 1'b0, 2'd0, 8'h00, 8'h00, "rd0_a0_clean");
      do_access(1'b1, 1'b0, 2'd2, 8'h00, 8'hA5, "rd1_a2_keep");

      // Both requests held from reset release: grants 0,1,0,1 every 2 cycles.
      do_reset(1'b1);
      exp_a0 = 4'b0001;
      exp_a1 = 4'b0100;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("rr_ack0_c%0d", k), {31'b0, ack0}, {31'b0, exp_a0[k % 4]});
         chk($sformatf("rr_ack1_c%0d", k), {31'b0, ack1}, {31'b0, exp_a1[k % 4]});
      end
      @(negedge clk);
      req0 = 1'b0;
      req1 = 1'b0;
      @(posedge clk);
      #1;
      chk("rr_stop_ack0", {31'b0, ack0}, 32'd0);
      chk("rr_stop_ack1", {31'b0, ack1}, 32'd0);

      // Reset pulsed during the ACCESS cycle of a write aborts it.
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b1; addr0 = 2'd1; wdata0 = 8'h3C;
      @(posedge clk);
      #1;
      chk("abort_pre_ack0", {31'b0, ack0}, 32'd1);
      #1;
      rst  = 1'b1;
      req0 = 1'b0;
      #1;
      chk("abort_ack0", {31'b0, ack0}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_post_ack0", {31'b0, ack0}, 32'd0);
      chk("abort_post_ack1", {31'b0, ack1}, 32'd0);
      do_access(1'b0, 1'b0, 2'd1, 8'h00, 8'h00, "abort_rd_a1");

      // Both write addr 0 together: 0 wins first (0x11), then 1 (0x22).
      do_reset(1'b0);
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b1; addr0 = 2'd0; wdata0 = 8'h11;
      req1 = 1'b1; we1 = 1'b1; addr1 = 2'd0; wdata1 = 8'h22;
      @(posedge clk);
      #1;
      chk("same_ack0",   {31'b0, ack0}, 32'd1);
      chk("same_ack1a",  {31'b0, ack1}, 32'd0);
      chk("same_rdata0", {24'b0, rdata0}, 32'h00);
      req0 = 1'b0;
      @(posedge clk);
      #1;
      chk("same_gap0", {31'b0, ack0}, 32'd0);
      chk("same_gap1", {31'b0, ack1}, 32'd0);
      @(posedge clk);
      #1;
      chk("same_ack1",   {31'b0, ack1}, 32'd1);
      chk("same_ack0b",  {31'b0, ack0}, 32'd0);
      chk("same_rdata1", {24'b0, rdata1}, 32'h11);
      req1 = 1'b0;
      @(posedge clk);
      #1;
      chk("same_end1", {31'b0, ack1}, 32'd0);
      do_access(1'b0, 1'b0, 2'd0, 8'h00, 8'h22, "same_final");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
